subpel_block_collector: RTL and testbench



---
 rtl/subpel_pkg.sv | 23 ++
 rtl/subpel_block_collector_if.sv | 27 ++
 rtl/subpel_row_mux.sv | 24 ++
 rtl/subpel_block_collector.sv | 198 +++++++++++++++++++
 tb/tb_subpel_block_collector.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/subpel_pkg.sv
// Shared constants, phase encodings and collector states for the sub-pel block collector.
package subpel_pkg;

    localparam int PIXEL_W   = 8;
    localparam int NUM_PIXEL = 8;
    localparam int ROW_W     = 64;
    localparam int BLK_W     = 512;

    typedef enum logic [1:0] {
        FRAC_INT  = 2'd0,
        FRAC_Q1   = 2'd1,
        FRAC_HALF = 2'd2,
        FRAC_Q3   = 2'd3
    } frac_e;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_e;

    typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/subpel_block_collector_if.sv
// Row-stream input and block-output handshake bundle of the sub-pel block collector.
interface subpel_block_collector_if;
    import subpel_pkg::*;

    logic             in_valid;
    logic             in_ready;
    row_t             in_row_int;
    row_t             in_row_a;
    row_t             in_row_b;
    row_t             in_row_c;
    logic [1:0]       frac_sel;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_block;
    logic [1:0]       out_frac;

    modport master (
        output in_valid, in_row_int, in_row_a, in_row_b, in_row_c, frac_sel, out_ready,
        input  in_ready, out_valid, out_block, out_frac
    );

    modport slave (
        input  in_valid, in_row_int, in_row_a, in_row_b, in_row_c, frac_sel, out_ready,
        output in_ready, out_valid, out_block, out_frac
    );

endinterface

// File: rtl/subpel_row_mux.sv
// Combinational 4:1 phase select of one pixel row; shared with the vertical pass.
module subpel_row_mux
    import subpel_pkg::*;
(
    input  logic [1:0] frac,
    input  row_t       row_int,
    input  row_t       row_a,
    input  row_t       row_b,
    input  row_t       row_c,
    output row_t       row
);

    always_comb begin
        row = row_int;
        case (frac_e'(frac))
            FRAC_INT:  row = row_int;
            FRAC_Q1:   row = row_a;
            FRAC_HALF: row = row_b;
            FRAC_Q3:   row = row_c;
            default:   row = row_int;
        endcase
    end

endmodule

// File: rtl/subpel_block_collector.sv
// Packs 8 phase-selected rows into a 512-bit prediction block with a valid/ready output.
// SUBPEL_COLLECT_DOUBLE_BUF_EN adds a second block bank for bubble-free streaming.
module subpel_block_collector #(
    parameter int NUM_PIXEL = 8,
    parameter int PIXEL_W   = 8,
    parameter int CNT_W     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    subpel_block_collector_if.slave bus,
    output logic [CNT_W-1:0]        blk_cnt
);
    import subpel_pkg::*;

    localparam int LINE_W = NUM_PIXEL * PIXEL_W;
    localparam int RC_W   = (NUM_PIXEL > 1) ? $clog2(NUM_PIXEL) : 1;
    localparam logic [RC_W-1:0] LAST_ROW = RC_W'(NUM_PIXEL - 1);

    logic [RC_W-1:0]   row_cnt_reg;
    logic [1:0]        blk_frac_reg;
    logic [1:0]        row_frac;
    logic [LINE_W-1:0] sel_row;
    logic              wr_en;
    logic              last_beat;
    logic [CNT_W-1:0]  blk_cnt_reg;

    genvar gi;

    // The first row of a block takes its phase live; later rows reuse the latched phase.
    assign row_frac  = (row_cnt_reg == '0) ? bus.frac_sel : blk_frac_reg;
    assign wr_en     = bus.in_valid && bus.in_ready && !flush;
    assign last_beat = wr_en && (row_cnt_reg == LAST_ROW);

    subpel_row_mux u_row_mux (
        .frac    (row_frac),
        .row_int (bus.in_row_int),
        .row_a   (bus.in_row_a),
        .row_b   (bus.in_row_b),
        .row_c   (bus.in_row_c),
        .row     (sel_row)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_cnt_reg  <= '0;
            blk_frac_reg <= FRAC_INT;
        end else if (flush) begin
            row_cnt_reg <= '0;
        end else if (wr_en) begin
            row_cnt_reg <= last_beat ? '0 : row_cnt_reg + 1'b1;
            if (row_cnt_reg == '0) begin
                blk_frac_reg <= bus.frac_sel;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blk_cnt_reg <= '0;
        end else if (last_beat) begin
            blk_cnt_reg <= blk_cnt_reg + 1'b1;
        end
    end

    assign blk_cnt = blk_cnt_reg;

`ifdef SUBPEL_COLLECT_DOUBLE_BUF_EN
    logic [1:0] full_reg;
    logic [1:0] full_next;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] bank_frac_reg [2];
    logic       drain;

    assign bus.in_ready  = ~&full_reg;
    assign bus.out_valid = full_reg[rd_ptr_reg];
    assign bus.out_frac  = bank_frac_reg[rd_ptr_reg];
    assign drain         = bus.out_valid && bus.out_ready;

    // Drain and completion always touch different banks, so both updates may apply together.
    always_comb begin
        full_next = full_reg;
        if (drain) begin
            full_next[rd_ptr_reg] = 1'b0;
        end
        if (last_beat) begin
            full_next[wr_ptr_reg] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_reg         <= '0;
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            bank_frac_reg[0] <= FRAC_INT;
            bank_frac_reg[1] <= FRAC_INT;
        end else begin
            full_reg <= full_next;
            if (last_beat) begin
                wr_ptr_reg                <= ~wr_ptr_reg;
                bank_frac_reg[wr_ptr_reg] <= row_frac;
            end
            if (drain) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    for (gi = 0; gi < NUM_PIXEL; gi++) begin : g_row
        logic [LINE_W-1:0] bank0_reg;
        logic [LINE_W-1:0] bank1_reg;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                bank0_reg <= '0;
                bank1_reg <= '0;
            end else if (wr_en && (row_cnt_reg == RC_W'(gi))) begin
                if (wr_ptr_reg) begin
                    bank1_reg <= sel_row;
                end else begin
                    bank0_reg <= sel_row;
                end
            end
        end

        assign bus.out_block[gi*LINE_W +: LINE_W] = rd_ptr_reg ? bank1_reg : bank0_reg;
    end
`else
    state_e     state_reg;
    state_e     state_next;
    logic [1:0] out_frac_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_COLLECT: if (last_beat)     state_next = ST_FULL;
            ST_FULL:    if (bus.out_ready) state_next = ST_COLLECT;
            default:                       state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bus.in_ready  = (state_reg == ST_COLLECT);
    assign bus.out_valid = (state_reg == ST_FULL);
    assign bus.out_frac  = out_frac_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_frac_reg <= FRAC_INT;
        end else if (last_beat) begin
            out_frac_reg <= row_frac;
        end
    end

    // The output copy is separate from the fill buffer so it survives the next block's writes.
    for (gi = 0; gi < NUM_PIXEL; gi++) begin : g_row
        logic [LINE_W-1:0] out_row_reg;

        if (gi < NUM_PIXEL - 1) begin : g_buf
            logic [LINE_W-1:0] row_buf_reg;

            always_ff @(posedge clock) begin
                if (wr_en && (row_cnt_reg == RC_W'(gi))) begin
                    row_buf_reg <= sel_row;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_row_reg <= '0;
                end else if (last_beat) begin
                    out_row_reg <= row_buf_reg;
                end
            end
        end else begin : g_last
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_row_reg <= '0;
                end else if (last_beat) begin
                    out_row_reg <= sel_row;
                end
            end
        end

        assign bus.out_block[gi*LINE_W +: LINE_W] = out_row_reg;
    end
`endif

endmodule

// File: tb/tb_subpel_block_collector.sv
// Randomized bench for subpel_block_collector against a queue-based block reference model.
module tb_subpel_block_collector;
    import subpel_pkg::*;

    localparam int CNT_W = 8;
`ifdef SUBPEL_COLLECT_DOUBLE_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] blk_cnt;

    always #5 clock = ~clock;

    subpel_block_collector_if bus();

    subpel_block_collector #(
        .NUM_PIXEL (8),
        .PIXEL_W   (8),
        .CNT_W     (CNT_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .bus     (bus),
        .blk_cnt (blk_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int drops    = 0;

    // Reference model: rows gathered so far, queue of finished blocks awaiting drain.
    logic [63:0]  m_rows[$];
    logic [1:0]   m_phase;
    logic [511:0] m_pend_blk[$];
    logic [1:0]   m_pend_frac[$];
    logic [511:0] m_last_blk;
    logic [1:0]   m_last_frac;
    int           m_cnt;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_rows.delete();
        m_pend_blk.delete();
        m_pend_frac.delete();
        m_phase     = 2'd0;
        m_last_blk  = '0;
        m_last_frac = 2'd0;
        m_cnt       = 0;
    endtask

    // One clock of the block-level rules, using the inputs that were present at the edge.
    task automatic model_step();
        logic         rdy;
        logic [63:0]  r;
        logic [511:0] blk;
        rdy = (m_pend_blk.size() < CAP);
        if (m_pend_blk.size() > 0 && bus.out_ready) begin
            void'(m_pend_blk.pop_front());
            void'(m_pend_frac.pop_front());
        end
        if (flush) begin
            m_rows.delete();
        end else if (bus.in_valid && rdy) begin
            if (m_rows.size() == 0) m_phase = bus.frac_sel;
            case (m_phase)
                2'd0:    r = bus.in_row_int;
                2'd1:    r = bus.in_row_a;
                2'd2:    r = bus.in_row_b;
                default: r = bus.in_row_c;
            endcase
            m_rows.push_back(r);
            if (m_rows.size() == 8) begin
                for (int i = 0; i < 8; i++) blk[i*64 +: 64] = m_rows[i];
                m_pend_blk.push_back(blk);
                m_pend_frac.push_back(m_phase);
                m_last_blk  = blk;
                m_last_frac = m_phase;
                m_cnt++;
                m_rows.delete();
            end
        end
    endtask

    task automatic check_outputs();
        check("in_ready", bus.in_ready, m_pend_blk.size() < CAP);
        check("out_valid", bus.out_valid, m_pend_blk.size() > 0);
        check("blk_cnt", blk_cnt, m_cnt[CNT_W-1:0]);
        if (m_pend_blk.size() > 0) begin
            check("out_block", bus.out_block, m_pend_blk[0]);
            check("out_frac", bus.out_frac, m_pend_frac[0]);
        end else begin
`ifndef SUBPEL_COLLECT_DOUBLE_BUF_EN
            check("held_block", bus.out_block, m_last_blk);
            check("held_frac", bus.out_frac, m_last_frac);
`endif
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] f, input logic fl, input logic ordy,
                         input logic [63:0] ri, input logic [63:0] ra,
                         input logic [63:0] rb, input logic [63:0] rc);
        bus.in_valid   = v;
        bus.frac_sel   = f;
        flush          = fl;
        bus.out_ready  = ordy;
        bus.in_row_int = ri;
        bus.in_row_a   = ra;
        bus.in_row_b   = rb;
        bus.in_row_c   = rc;
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
        if (!bus.in_ready) drops++;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic rnd_beat(input logic v, input logic [1:0] f, input logic fl, input logic ordy);
        drive(v, f, fl, ordy, rnd64(), rnd64(), rnd64(), rnd64());
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 2'd0, 1'b0, ordy, '0, '0, '0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        model_clear();
        #2;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_block", bus.out_block, '0);
        check("rst_out_frac", bus.out_frac, 2'd0);
        check("rst_blk_cnt", blk_cnt, '0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [511:0] exp_blk;
        logic [7:0]   pix;
        int           guard;

        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.frac_sel   = 2'd0;
        bus.in_row_int = '0;
        bus.in_row_a   = '0;
        bus.in_row_b   = '0;
        bus.in_row_c   = '0;
        model_clear();

        // Half-pel block with a known ramp pattern on the B rows.
        apply_reset();
        for (int r = 0; r < 8; r++) begin
            pix = 8'h10 + 8'(r);
            exp_blk[r*64 +: 64] = {8{pix}};
            drive(1'b1, (r == 0) ? 2'd2 : 2'd0, 1'b0, 1'b1, rnd64(), rnd64(), {8{pix}}, rnd64());
        end
        check("tp1_valid", bus.out_valid, 1'b1);
        check("tp1_block", bus.out_block, exp_blk);
        check("tp1_frac", bus.out_frac, 2'd2);
        check("tp1_cnt", blk_cnt, 8'd1);
        idle(1'b1);

        // Downstream stalls for 5 cycles after completion.
        for (int r = 0; r < 8; r++) rnd_beat(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Flush after 3 beats, then a quarter-pel block.
        for (int r = 0; r < 3; r++) rnd_beat(1'b1, 2'd2, 1'b0, 1'b1);
        rnd_beat(1'b0, 2'd0, 1'b1, 1'b1);
        for (int r = 0; r < 8; r++) rnd_beat(1'b1, 2'd1, 1'b0, 1'b1);
        idle(1'b1);

        // Flush coincident with a valid beat at row 4.
        for (int r = 0; r < 4; r++) rnd_beat(1'b1, 2'd3, 1'b0, 1'b1);
        rnd_beat(1'b1, 2'd3, 1'b1, 1'b1);
        for (int r = 0; r < 8; r++) rnd_beat(1'b1, 2'd0, 1'b0, 1'b1);
        idle(1'b1);

        // Reset in the middle of a block.
        for (int r = 0; r < 5; r++) rnd_beat(1'b1, 2'd2, 1'b0, 1'b1);
        apply_reset();
        for (int r = 0; r < 8; r++) rnd_beat(1'b1, 2'd3, 1'b0, 1'b1);
        check("rst_mid_cnt", blk_cnt, 8'd1);
        check("rst_mid_frac", bus.out_frac, 2'd3);
        idle(1'b1);

        // 256 back-to-back blocks: counter wrap and bubble behaviour.
        apply_reset();
        drops = 0;
        guard = 0;
        while (m_cnt < 256 && guard < 5000) begin
            rnd_beat(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
            guard++;
        end
        check("wrap_done", m_cnt == 256, 1'b1);
        check("wrap_cnt", blk_cnt, '0);
`ifdef SUBPEL_COLLECT_DOUBLE_BUF_EN
        check("no_bubble", drops, 0);
`else
        check("bubble", drops >= 256, 1'b1);
`endif
        idle(1'b1);

        // Random traffic with stalls, gaps and flushes.
        for (int i = 0; i < 3000; i++) begin
            rnd_beat($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
